// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared request-unit state encoding and watchdog default
package cpu_types_pkg;
    typedef enum logic [1:0] {
        REQ_FETCH = 2'd0,
        REQ_DATA  = 2'd1,
        REQ_HALT  = 2'd2
    } req_state_t;
    localparam int REQ_WD_DEFAULT = 1024;
endpackage

// File: rtl/request_unit_if.sv
// request_unit_if: control/cache handshake bundle between decoder, request unit and cache
interface request_unit_if #(parameter int CNT_W = 32);
    logic             iREN;
    logic             memtoReg;
    logic             memWr;
    logic             halt;
    logic             ihit;
    logic             dhit;
    logic             imemREN;
    logic             dmemREN;
    logic             dmemWEN;
    logic             pc_en;
    logic             halted;
    logic             wd_err;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output iREN, memtoReg, memWr, halt, ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, pc_en, halted, wd_err, stall_cnt
    );
    modport slave (
        input  iREN, memtoReg, memWr, halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pc_en, halted, wd_err, stall_cnt
    );
endinterface

// File: rtl/request_unit_sat_counter.sv
// req_sat_counter: saturating up-counter with synchronous clear (clear beats enable)
module req_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Next count: clear, else increment unless already all-ones
    always_comb cnt_d = clr_i ? '0 : (en_i && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;

    // Count register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/request_unit.sv
// request_unit: turns decoded memory/halt controls into cache requests and releases the PC on hit.
// Optional data-request watchdog enabled by defining REQUEST_WATCHDOG_EN.
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int WD_CYCLES = REQ_WD_DEFAULT,
    parameter int CNT_W     = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    request_unit_if.slave   ru
);
    req_state_t state_q, state_d;
    logic       rd_q, rd_d, wr_q, wr_d;
    logic       is_mem, fetch_to_data, data_wait, wd_fire;

    assign is_mem        = ru.memtoReg | ru.memWr;
    assign fetch_to_data = (state_q == REQ_FETCH) && ru.ihit && !ru.halt && is_mem;
    assign data_wait     = (state_q == REQ_DATA) && !ru.dhit;

    // State register
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) state_q <= REQ_FETCH;
        else       state_q <= state_d;

    // Next-state: halt beats memory ops on ihit; dhit beats the watchdog; HALT only exits via reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            REQ_FETCH: state_d = !ru.ihit ? REQ_FETCH : ru.halt ? REQ_HALT : is_mem ? REQ_DATA : REQ_FETCH;
            REQ_DATA:  state_d = ru.dhit ? REQ_FETCH : wd_fire ? REQ_HALT : REQ_DATA;
            default:   state_d = REQ_HALT;
        endcase
    end

    // Access type latched at ihit; load wins an illegal load+store decode, cleared on leaving DATA
    always_comb begin
        rd_d = fetch_to_data ? ru.memtoReg : (state_d == REQ_DATA) ? rd_q : 1'b0;
        wr_d = fetch_to_data ? (ru.memWr & ~ru.memtoReg) : (state_d == REQ_DATA) ? wr_q : 1'b0;
    end

    // Type registers
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end

    // Output decode from current state; pc_en retires in the hit cycle itself
    always_comb begin
        ru.imemREN = (state_q == REQ_FETCH) ? ru.iREN : 1'b0;
        ru.dmemREN = (state_q == REQ_DATA) & rd_q;
        ru.dmemWEN = (state_q == REQ_DATA) & wr_q;
        ru.pc_en   = ((state_q == REQ_FETCH) & ru.ihit & ~ru.halt & ~is_mem) | ((state_q == REQ_DATA) & ru.dhit);
        ru.halted  = (state_q == REQ_HALT);
    end

    req_sat_counter #(.W(CNT_W)) u_stall (
        .clk   (CLK),
        .rst_n (nRST),
        .en_i  (data_wait),
        .clr_i (1'b0),
        .cnt_o (ru.stall_cnt)
    );

`ifdef REQUEST_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_err_q;

    // Fires in the WD_CYCLES-th consecutive DATA cycle without dhit
    assign wd_fire = data_wait && (wd_cnt == WD_W'(WD_CYCLES - 1));

    req_sat_counter #(.W(WD_W)) u_wd (
        .clk   (CLK),
        .rst_n (nRST),
        .en_i  (data_wait),
        .clr_i (fetch_to_data),
        .cnt_o (wd_cnt)
    );

    // Sticky watchdog error flag
    always_ff @(posedge CLK or negedge nRST)
        if (!nRST) wd_err_q <= 1'b0;
        else       wd_err_q <= wd_err_q | wd_fire;

    assign ru.wd_err = wd_err_q;
`else
    assign wd_fire   = 1'b0;
    assign ru.wd_err = 1'b0;
`endif
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed checks of fetch, load/store, halt, reset and watchdog behaviour
module tb_request_unit;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    request_unit_if #(.CNT_W(32)) bus ();

    request_unit #(.WD_CYCLES(8), .CNT_W(32)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .ru   (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs just after the falling edge, then settle before sampling
    task automatic step(input logic iren, input logic mr, input logic mw, input logic h, input logic ih, input logic dh);
        @(negedge clk);
        bus.iREN = iren; bus.memtoReg = mr; bus.memWr = mw; bus.halt = h; bus.ihit = ih; bus.dhit = dh;
        #1;
    endtask

    initial begin
        bus.iREN = 0; bus.memtoReg = 0; bus.memWr = 0; bus.halt = 0; bus.ihit = 0; bus.dhit = 0;
        // Reset state
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_imemREN", bus.imemREN, 1);
        check("rst_dmemREN", bus.dmemREN, 0);
        check("rst_dmemWEN", bus.dmemWEN, 0);
        check("rst_pc_en", bus.pc_en, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_stall", bus.stall_cnt, 0);
        check("rst_wd_err", bus.wd_err, 0);
        nrst = 1;
        // 1: ALU op, ihit in cycle 3
        step(1, 0, 0, 0, 0, 0);
        check("alu_c1_pc_en", bus.pc_en, 0);
        step(1, 0, 0, 0, 0, 0);
        check("alu_c2_pc_en", bus.pc_en, 0);
        step(1, 0, 0, 0, 1, 0);
        check("alu_c3_pc_en", bus.pc_en, 1);
        check("alu_c3_dmem", {bus.dmemREN, bus.dmemWEN}, 0);
        step(1, 0, 0, 0, 0, 0);
        check("alu_c4_pc_en", bus.pc_en, 0);
        check("alu_c4_imemREN", bus.imemREN, 1);
        // 2: LW, ihit at cycle 2, dhit at cycle 6; ihit in DATA is ignored
        step(1, 1, 0, 0, 1, 0);
        check("lw_c2_pc_en", bus.pc_en, 0);
        check("lw_c2_dmemREN", bus.dmemREN, 0);
        for (int i = 3; i <= 5; i++) begin
            step(1, 0, 0, 0, i == 4, 0);
            check("lw_wait_dmemREN", bus.dmemREN, 1);
            check("lw_wait_dmemWEN", bus.dmemWEN, 0);
            check("lw_wait_imemREN", bus.imemREN, 0);
            check("lw_wait_pc_en", bus.pc_en, 0);
        end
        step(1, 0, 0, 0, 0, 1);
        check("lw_c6_dmemREN", bus.dmemREN, 1);
        check("lw_c6_pc_en", bus.pc_en, 1);
        check("lw_c6_imemREN", bus.imemREN, 0);
        step(1, 0, 0, 0, 0, 0);
        check("lw_after_dmemREN", bus.dmemREN, 0);
        check("lw_after_imemREN", bus.imemREN, 1);
        check("lw_stall_cnt", bus.stall_cnt, 3);
        // 3: SW with ihit & dhit together on the first DATA cycle
        step(1, 0, 1, 0, 1, 0);
        check("sw_issue_pc_en", bus.pc_en, 0);
        step(1, 0, 0, 0, 1, 1);
        check("sw_dmemWEN", bus.dmemWEN, 1);
        check("sw_dmemREN", bus.dmemREN, 0);
        check("sw_pc_en", bus.pc_en, 1);
        step(1, 0, 0, 0, 0, 0);
        check("sw_after_dmemWEN", bus.dmemWEN, 0);
        check("sw_after_imemREN", bus.imemREN, 1);
        check("sw_stall_cnt", bus.stall_cnt, 3);
        // Illegal load+store decode: load wins
        step(1, 1, 1, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        check("ill_dmemREN", bus.dmemREN, 1);
        check("ill_dmemWEN", bus.dmemWEN, 0);
        check("ill_pc_en", bus.pc_en, 1);
        // 5: reset mid-LW drops requests immediately
        step(1, 1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rlw_dmemREN", bus.dmemREN, 1);
        nrst = 0;
        #1;
        check("rlw_rst_dmemREN", bus.dmemREN, 0);
        check("rlw_rst_imemREN", bus.imemREN, 1);
        check("rlw_rst_stall", bus.stall_cnt, 0);
        step(1, 0, 0, 0, 0, 0);
        nrst = 1;
        check("rlw_fetch_imemREN", bus.imemREN, 1);
        // 6: LW that never gets dhit
        step(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 0, 0, 0);
            check("wd_wait_dmemREN", bus.dmemREN, 1);
            check("wd_wait_halted", bus.halted, 0);
        end
        step(1, 0, 0, 0, 0, 0);
`ifdef REQUEST_WATCHDOG_EN
        check("wd_err", bus.wd_err, 1);
        check("wd_halted", bus.halted, 1);
        check("wd_dmemREN", bus.dmemREN, 0);
`else
        check("wd_err", bus.wd_err, 0);
        check("wd_halted", bus.halted, 0);
        check("wd_dmemREN", bus.dmemREN, 1);
`endif
        check("wd_stall_cnt", bus.stall_cnt, 8);
        nrst = 0;
        step(1, 0, 0, 0, 0, 0);
        nrst = 1;
        // 4: HALT together with memWr
        step(1, 0, 1, 1, 1, 0);
        check("halt_pc_en", bus.pc_en, 0);
        check("halt_dmemWEN", bus.dmemWEN, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0, 1, 1);
            check("halt_halted", bus.halted, 1);
            check("halt_dmemWEN_hold", bus.dmemWEN, 0);
            check("halt_imemREN", bus.imemREN, 0);
            check("halt_pc_en_hold", bus.pc_en, 0);
        end
        check("halt_wd_err", bus.wd_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
